stream_merge_ctrl: RTL and testbench
====================================

# stream_merge_ctrl

Control-driven two-to-one stream merger. It sits between two producer element streams of the generated `top` pipeline and a single consumer stream. Each stream carries an element plus an end-of-stream (EOS) flag.

- Arms on one `inCtrl` token.
- Interleaves elements from the two inputs round-robin into a one-entry output register.
- Swallows the per-input EOS markers and emits exactly one merged EOS once both inputs have ended.
- Then returns one `outCtrl` token and re-arms.

## Interface
Parameters:
- `DATA_WIDTH`, default 64: element payload width (`field0`).

Ports:
- `clock`, input, 1: clock.
- `reset`, input, 1: reset, synchronous, active-high.
- `inCtrl_valid`, input, 1: start token offered.
- `inCtrl_ready`, output, 1: start token accepted.
- `in0_valid`, input, 1: input 0 element offered.
- `in0_ready`, output, 1: input 0 element consumed.
- `in0_data_field0`, input, `DATA_WIDTH`: input 0 element value.
- `in0_data_field1`, input, 1: input 0 EOS flag (1 = EOS marker, `field0` ignored).
- `in1_valid`, `in1_ready`, `in1_data_field0`, `in1_data_field1`: input 1, same widths and meanings as input 0.
- `out0_valid`, output, 1: merged element offered.
- `out0_ready`, input, 1: consumer accepts.
- `out0_data_field0`, output, `DATA_WIDTH`: merged element value.
- `out0_data_field1`, output, 1: merged EOS flag.
- `outCtrl_valid`, output, 1: completion token offered.
- `outCtrl_ready`, input, 1: completion token accepted.

## Operation
State machine states: IDLE, RUN, FLUSH, DONE. Internal registers:
- `done0`, `done1`: per-input EOS seen.
- `rr`: round-robin pointer, 0 or 1.
- Output slot: `out0_valid` and the two data fields.

Definitions:
- `free` = !`out0_valid` || `out0_ready`. The slot can load this cycle.
- Input i is eligible = `in{i}_valid` && !`done{i}`.
- Grant, RUN only, and only when `free`:
  - Input `rr` if it is eligible.
  - Otherwise the other input if it is eligible.
  - Otherwise none.
- `in{i}_ready` = grant == i. It is combinational from valid, state, done flags and `out0_ready`. It is 0 in every state other than RUN.

State behaviour:
- IDLE:
  - `inCtrl_ready` = 1.
  - On `inCtrl_valid`: go to RUN and clear `done0`, `done1` and `rr`.
- RUN, on a grant to input i (handshake fires):
  - `field1` = 0: load the slot with `{field0, 0}` and set `out0_valid`.
  - `field1` = 1: set `done{i}`. Nothing is loaded into the slot. If `free`, clear `out0_valid`.
  - In both cases set `rr` = 1 − i.
- RUN, with no grant and `free`: clear `out0_valid`.
- RUN → FLUSH: when `done0` && `done1` (registered) and `free`. This loads the EOS token `{0, 1}` and sets `out0_valid`.
- FLUSH:
  - Hold the EOS token until `out0_ready`.
  - Then clear `out0_valid` and go to DONE.
- DONE:
  - `outCtrl_valid` = 1.
  - On `outCtrl_ready`: go to IDLE.
- `inCtrl_valid` outside IDLE is not accepted (`inCtrl_ready` = 0) and stays pending.
- The output slot holds its data stable while `out0_valid` && !`out0_ready`.

## Timing
Reset:
- While `reset` is high and on the cycle it is sampled:
  - State becomes IDLE.
  - `out0_valid` = 0, `out0_data_field0` = 0, `out0_data_field1` = 0.
  - `outCtrl_valid` = 0.
  - `done0` = `done1` = 0, `rr` = 0.
- `inCtrl_ready` is forced 0 while `reset` = 1.
- Reset mid-operation discards the slot contents and all flags. No EOS or `outCtrl` is emitted.

Latency and throughput:
- Input handshake in cycle n → `out0_valid` with that element in cycle n+1.
- Throughput is one element per cycle while the consumer holds `out0_ready` = 1. The slot reloads in the same cycle it drains.

Boundary conditions:
- Both inputs valid with `rr` = 0: input 0 is served, then input 1 the next cycle. They alternate while both stay valid.
- EOS markers on both inputs in the same cycle: only one is granted per cycle. The second is taken the next cycle.
- An input that has sent EOS is never granted again in this run. Its further valids are left pending.
- Consuming an EOS marker takes one grant cycle but produces no output beat.
- The merged EOS appears no earlier than the cycle after the second `done` flag is set. It is always the last beat of the run.
- From the `out0` EOS handshake to `outCtrl_valid` is 1 cycle.
- Back-to-back runs: an `inCtrl` token pending in DONE is accepted in the cycle after `outCtrl` completes, i.e. in IDLE.

## Test plan
- **Basic merge.** `inCtrl` pulse; input 0 sends 1, 2, EOS and input 1 sends 10, 20, EOS, all continuously valid; `out0_ready` = 1. Required `out0` sequence: 1, 10, 2, 20, EOS. Then `outCtrl_valid` is high exactly 1 cycle after the EOS handshake.
- **Consumer backpressure.** Same stimulus as basic merge, with `out0_ready` toggled 1,0,0,1 repeating. Required: identical output order; `out0` data stable while stalled; no element lost or duplicated.
- **Empty inputs.** Both inputs send EOS only. Required: a single `out0` beat with `field1` = 1 and `field0` = 0, then `outCtrl`.
- **Unbalanced inputs.** Input 0 sends EOS immediately; input 1 sends 5, 6, 7, EOS. Required output: 5, 6, 7, EOS. `in0_ready` is never asserted after input 0's EOS.
- **Not armed, then reset mid-run.** Inputs valid before any `inCtrl`: required `in0_ready` = `in1_ready` = 0 and `out0_valid` = 0. Then arm, pass two elements, assert `reset` for 1 cycle. Required: `out0_valid` = 0, no EOS, no `outCtrl`. A fresh `inCtrl` then runs a complete merge correctly.

Source files
------------

// File: rtl/stream_merge_ctrl.sv
// stream_merge_ctrl: control-armed two-to-one round-robin stream merger.
// Each run starts on one inCtrl token, interleaves elements from in0/in1
// into a one-entry output slot, absorbs the per-input EOS markers, emits a
// single merged EOS once both inputs have ended, then offers one outCtrl
// token before re-arming.
module stream_merge_ctrl #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inCtrl_valid,
  output logic                  inCtrl_ready,
  input  logic                  in0_valid,
  output logic                  in0_ready,
  input  logic [DATA_WIDTH-1:0] in0_data_field0,
  input  logic                  in0_data_field1,
  input  logic                  in1_valid,
  output logic                  in1_ready,
  input  logic [DATA_WIDTH-1:0] in1_data_field0,
  input  logic                  in1_data_field1,
  output logic                  out0_valid,
  input  logic                  out0_ready,
  output logic [DATA_WIDTH-1:0] out0_data_field0,
  output logic                  out0_data_field1,
  output logic                  outCtrl_valid,
  input  logic                  outCtrl_ready
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                r_state;
  logic                  r_done0;
  logic                  r_done1;
  logic                  r_rr;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_f0;
  logic                  r_out_f1;

  state_t                w_state_nx;
  logic                  w_done0_nx;
  logic                  w_done1_nx;
  logic                  w_rr_nx;
  logic                  w_out_valid_nx;
  logic [DATA_WIDTH-1:0] w_out_f0_nx;
  logic                  w_out_f1_nx;

  logic                  w_free;
  logic                  w_elig0;
  logic                  w_elig1;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic [DATA_WIDTH-1:0] w_sel_f0;
  logic                  w_sel_eos;

  assign w_free  = !r_out_valid || out0_ready;
  assign w_elig0 = in0_valid && !r_done0;
  assign w_elig1 = in1_valid && !r_done1;

  // Round-robin grant: favour input rr, fall back to the other; only in RUN with a free slot.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == S_RUN && w_free) begin
      if (!r_rr) begin
        if (w_elig0)      w_gnt0 = 1'b1;
        else if (w_elig1) w_gnt1 = 1'b1;
      end else begin
        if (w_elig1)      w_gnt1 = 1'b1;
        else if (w_elig0) w_gnt0 = 1'b1;
      end
    end
  end

  assign w_sel_f0  = w_gnt0 ? in0_data_field0 : in1_data_field0;
  assign w_sel_eos = w_gnt0 ? in0_data_field1 : in1_data_field1;

  // Next-state and slot update logic; every register holds unless a case below changes it.
  always_comb begin
    w_state_nx     = r_state;
    w_done0_nx     = r_done0;
    w_done1_nx     = r_done1;
    w_rr_nx        = r_rr;
    w_out_valid_nx = r_out_valid;
    w_out_f0_nx    = r_out_f0;
    w_out_f1_nx    = r_out_f1;
    case (r_state)
      S_IDLE: begin
        if (inCtrl_valid) begin
          w_state_nx = S_RUN;
          w_done0_nx = 1'b0;
          w_done1_nx = 1'b0;
          w_rr_nx    = 1'b0;
        end
      end
      S_RUN: begin
        if (r_done0 && r_done1) begin
          // Both inputs ended: the merged EOS replaces the slot once it drains.
          if (w_free) begin
            w_out_valid_nx = 1'b1;
            w_out_f0_nx    = '0;
            w_out_f1_nx    = 1'b1;
            w_state_nx     = S_FLUSH;
          end
        end else if (w_gnt0 || w_gnt1) begin
          w_rr_nx = w_gnt0;
          if (w_sel_eos) begin
            // EOS markers are swallowed: they only set the done flag.
            w_out_valid_nx = 1'b0;
            if (w_gnt0) w_done0_nx = 1'b1;
            else        w_done1_nx = 1'b1;
          end else begin
            w_out_valid_nx = 1'b1;
            w_out_f0_nx    = w_sel_f0;
            w_out_f1_nx    = 1'b0;
          end
        end else if (w_free) begin
          w_out_valid_nx = 1'b0;
        end
      end
      S_FLUSH: begin
        if (out0_ready) begin
          w_out_valid_nx = 1'b0;
          w_state_nx     = S_DONE;
        end
      end
      S_DONE: begin
        if (outCtrl_ready) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // State, flag and output-slot registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_rr        <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_f0    <= '0;
      r_out_f1    <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_done0     <= w_done0_nx;
      r_done1     <= w_done1_nx;
      r_rr        <= w_rr_nx;
      r_out_valid <= w_out_valid_nx;
      r_out_f0    <= w_out_f0_nx;
      r_out_f1    <= w_out_f1_nx;
    end
  end

  assign inCtrl_ready     = (r_state == S_IDLE) && !reset;
  assign outCtrl_valid    = (r_state == S_DONE);
  assign in0_ready        = w_gnt0;
  assign in1_ready        = w_gnt1;
  assign out0_valid       = r_out_valid;
  assign out0_data_field0 = r_out_f0;
  assign out0_data_field1 = r_out_f1;

endmodule

// File: tb/tb_stream_merge_ctrl.sv
// Testbench for stream_merge_ctrl: table of merge scenarios with hand-written
// expected output order, a scoreboard queue of expected beats, and hand-written
// sequences for reset, not-armed and back-to-back behaviour.
module tb_stream_merge_ctrl;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          inCtrl_valid, inCtrl_ready;
  logic          in0_valid, in0_ready, in0_data_field1;
  logic [DW-1:0] in0_data_field0;
  logic          in1_valid, in1_ready, in1_data_field1;
  logic [DW-1:0] in1_data_field0;
  logic          out0_valid, out0_ready, out0_data_field1;
  logic [DW-1:0] out0_data_field0;
  logic          outCtrl_valid, outCtrl_ready;

  always #5 clock = ~clock;

  stream_merge_ctrl #(.DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .inCtrl_valid(inCtrl_valid), .inCtrl_ready(inCtrl_ready),
    .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in0_data_field0(in0_data_field0), .in0_data_field1(in0_data_field1),
    .in1_valid(in1_valid), .in1_ready(in1_ready),
    .in1_data_field0(in1_data_field0), .in1_data_field1(in1_data_field1),
    .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out0_data_field0(out0_data_field0), .out0_data_field1(out0_data_field1),
    .outCtrl_valid(outCtrl_valid), .outCtrl_ready(outCtrl_ready)
  );

  // One merge scenario: elements per input (EOS appended), expected data beats (EOS appended).
  typedef struct packed {
    int                 n0;
    logic [3:0][DW-1:0] d0;
    int                 n1;
    logic [3:0][DW-1:0] d1;
    int                 ne;
    logic [4:0][DW-1:0] ex;
    bit                 bp;
  } vec_t;

  vec_t tbl [6];

  logic [DW:0] q0[$];
  logic [DW:0] q1[$];
  logic [DW:0] sb[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic quiet_inputs();
    in0_valid = 1'b0; in0_data_field0 = '0; in0_data_field1 = 1'b0;
    in1_valid = 1'b0; in1_data_field0 = '0; in1_data_field1 = 1'b0;
  endtask

  task automatic arm();
    @(negedge clock);
    quiet_inputs();
    out0_ready   = 1'b1;
    inCtrl_valid = 1'b1;
    #1;
    chk("arm_inctrl_ready", 32'(inCtrl_ready), 32'd1);
  endtask

  task automatic run_stream(input int k, input bit b2b);
    int          cyc;
    int          illegal;
    int          g_cyc;
    int          v_cyc;
    bit          got_eos;
    bit          stall_prev;
    logic [DW:0] held;
    logic [DW:0] e;
    bit [3:0]    pat;
    pat = 4'b1001;
    q0.delete(); q1.delete(); sb.delete();
    for (int i = 0; i < tbl[k].n0; i++) q0.push_back({1'b0, tbl[k].d0[i]});
    q0.push_back({1'b1, {DW{1'b0}}});
    for (int i = 0; i < tbl[k].n1; i++) q1.push_back({1'b0, tbl[k].d1[i]});
    q1.push_back({1'b1, {DW{1'b0}}});
    for (int i = 0; i < tbl[k].ne; i++) sb.push_back({1'b0, tbl[k].ex[i]});
    sb.push_back({1'b1, {DW{1'b0}}});
    cyc = 0; illegal = 0; g_cyc = -1; v_cyc = -1;
    got_eos = 1'b0; stall_prev = 1'b0; held = '0;
    while (!got_eos && cyc < 300) begin
      @(negedge clock);
      inCtrl_valid = 1'b0;
      // After its EOS an input keeps offering junk, which must stay pending.
      in0_valid = 1'b1;
      if (q0.size() > 0) begin
        in0_data_field0 = q0[0][DW-1:0]; in0_data_field1 = q0[0][DW];
      end else begin
        in0_data_field0 = 16'hDEAD; in0_data_field1 = 1'b0;
      end
      in1_valid = 1'b1;
      if (q1.size() > 0) begin
        in1_data_field0 = q1[0][DW-1:0]; in1_data_field1 = q1[0][DW];
      end else begin
        in1_data_field0 = 16'hBEEF; in1_data_field1 = 1'b0;
      end
      out0_ready = tbl[k].bp ? pat[cyc % 4] : 1'b1;
      #1;
      if (stall_prev) begin
        chk("stall_valid", 32'(out0_valid), 32'd1);
        chk("stall_data", 32'({out0_data_field1, out0_data_field0}), 32'(held));
      end
      if (out0_valid && v_cyc < 0) v_cyc = cyc;
      if (in0_ready) begin
        if (q0.size() == 0) illegal++;
        else begin
          if (g_cyc < 0 && !q0[0][DW]) g_cyc = cyc;
          void'(q0.pop_front());
        end
      end
      if (in1_ready) begin
        if (q1.size() == 0) illegal++;
        else begin
          if (g_cyc < 0 && !q1[0][DW]) g_cyc = cyc;
          void'(q1.pop_front());
        end
      end
      if (out0_valid && out0_ready) begin
        if (sb.size() == 0) begin
          chk("extra_beat", 32'({out0_data_field1, out0_data_field0}), 32'hFFFFFFFF);
        end else begin
          e = sb.pop_front();
          chk($sformatf("beat_s%0d", k), 32'({out0_data_field1, out0_data_field0}), 32'(e));
          if (e[DW]) begin
            got_eos = 1'b1;
            chk("outctrl_before_eos", 32'(outCtrl_valid), 32'd0);
          end
        end
      end
      stall_prev = out0_valid && !out0_ready;
      held = {out0_data_field1, out0_data_field0};
      cyc++;
    end
    chk($sformatf("eos_seen_s%0d", k), 32'(got_eos), 32'd1);
    chk("illegal_ready", 32'(illegal), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    if (tbl[k].ne > 0) chk("first_latency", 32'(v_cyc), 32'(g_cyc + 1));
    // Completion token: one cycle after the EOS handshake, held until accepted.
    @(negedge clock);
    quiet_inputs();
    out0_ready = 1'b1; outCtrl_ready = 1'b0; inCtrl_valid = b2b;
    #1;
    chk("outctrl_lat", 32'(outCtrl_valid), 32'd1);
    chk("done_out0_idle", 32'(out0_valid), 32'd0);
    chk("done_inctrl_ready", 32'(inCtrl_ready), 32'd0);
    @(negedge clock);
    outCtrl_ready = 1'b1;
    #1;
    chk("outctrl_hold", 32'(outCtrl_valid), 32'd1);
    @(negedge clock);
    outCtrl_ready = 1'b0;
    #1;
    chk("outctrl_drop", 32'(outCtrl_valid), 32'd0);
    chk("idle_inctrl_ready", 32'(inCtrl_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{n0: 2, d0: {16'd0, 16'd0, 16'd2, 16'd1},
               n1: 2, d1: {16'd0, 16'd0, 16'd20, 16'd10},
               ne: 4, ex: {16'd0, 16'd20, 16'd2, 16'd10, 16'd1}, bp: 1'b0};
    tbl[1] = tbl[0];
    tbl[1].bp = 1'b1;
    tbl[2] = '{n0: 0, d0: '0, n1: 0, d1: '0, ne: 0, ex: '0, bp: 1'b0};
    tbl[3] = '{n0: 0, d0: '0,
               n1: 3, d1: {16'd0, 16'd7, 16'd6, 16'd5},
               ne: 3, ex: {16'd0, 16'd0, 16'd7, 16'd6, 16'd5}, bp: 1'b0};
    tbl[4] = '{n0: 3, d0: {16'd0, 16'd5, 16'd4, 16'd3},
               n1: 0, d1: '0,
               ne: 3, ex: {16'd0, 16'd0, 16'd5, 16'd4, 16'd3}, bp: 1'b1};
    tbl[5] = '{n0: 1, d0: {16'd0, 16'd0, 16'd0, 16'h77},
               n1: 3, d1: {16'd0, 16'h83, 16'h82, 16'h81},
               ne: 4, ex: {16'd0, 16'h83, 16'h82, 16'h81, 16'h77}, bp: 1'b0};

    reset = 1'b1; inCtrl_valid = 1'b0; out0_ready = 1'b1; outCtrl_ready = 1'b0;
    quiet_inputs();
    repeat (2) @(negedge clock);
    inCtrl_valid = 1'b1;
    #1;
    chk("rst_inctrl_ready", 32'(inCtrl_ready), 32'd0);
    chk("rst_out0_valid", 32'(out0_valid), 32'd0);
    chk("rst_out0_data", 32'({out0_data_field1, out0_data_field0}), 32'd0);
    chk("rst_outctrl", 32'(outCtrl_valid), 32'd0);
    inCtrl_valid = 1'b0;
    reset = 1'b0;

    // Not armed: offered inputs must not be consumed.
    repeat (3) begin
      @(negedge clock);
      in0_valid = 1'b1; in0_data_field0 = 16'h55; in0_data_field1 = 1'b0;
      in1_valid = 1'b1; in1_data_field0 = 16'h66; in1_data_field1 = 1'b0;
      #1;
      chk("unarmed_in0_ready", 32'(in0_ready), 32'd0);
      chk("unarmed_in1_ready", 32'(in1_ready), 32'd0);
      chk("unarmed_out0_valid", 32'(out0_valid), 32'd0);
    end

    arm();
    run_stream(0, 1'b1);
    run_stream(1, 1'b0);
    for (int k = 2; k < 6; k++) begin
      arm();
      run_stream(k, 1'b0);
    end

    // Reset in the middle of a run after two elements have passed.
    arm();
    @(negedge clock);
    inCtrl_valid = 1'b0;
    in0_valid = 1'b1; in0_data_field0 = 16'h11; in0_data_field1 = 1'b0;
    in1_valid = 1'b1; in1_data_field0 = 16'h21; in1_data_field1 = 1'b0;
    out0_ready = 1'b1;
    #1;
    chk("mid_grant0", 32'(in0_ready), 32'd1);
    @(negedge clock);
    #1;
    chk("mid_grant1", 32'(in1_ready), 32'd1);
    chk("mid_beat0", 32'({out0_valid, out0_data_field0}), 32'h10011);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_out0_valid", 32'(out0_valid), 32'd0);
    chk("midrst_out0_data", 32'({out0_data_field1, out0_data_field0}), 32'd0);
    chk("midrst_outctrl", 32'(outCtrl_valid), 32'd0);
    chk("midrst_inctrl_ready", 32'(inCtrl_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("postrst_inctrl_ready", 32'(inCtrl_ready), 32'd1);
    repeat (3) begin
      @(negedge clock);
      #1;
      chk("postrst_out0_valid", 32'(out0_valid), 32'd0);
      chk("postrst_outctrl", 32'(outCtrl_valid), 32'd0);
      chk("postrst_in_ready", 32'({in0_ready, in1_ready}), 32'd0);
    end
    arm();
    run_stream(0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
